// File: rtl/mem_arbiter_if.sv
// Two-port requester bus plus shared byte-memory bus for mem_arbiter.
// slave: arbiter view (requests/mem replies in, stalls/strobes out); master: the driving side.
interface mem_arbiter_if;
  logic       p0_read;
  logic       p0_write;
  logic [7:0] p0_address;
  logic [7:0] p0_writedata;
  logic [7:0] p0_readdata;
  logic       p0_busywait;
  logic       p1_read;
  logic       p1_write;
  logic [7:0] p1_address;
  logic [7:0] p1_writedata;
  logic [7:0] p1_readdata;
  logic       p1_busywait;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_writedata;
  logic [7:0] mem_readdata;
  logic       mem_ack;
  logic       timeout_err;

  modport slave (
    input  p0_read, p0_write, p0_address, p0_writedata,
    input  p1_read, p1_write, p1_address, p1_writedata,
    input  mem_readdata, mem_ack,
    output p0_readdata, p0_busywait,
    output p1_readdata, p1_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    output timeout_err
  );

  modport master (
    output p0_read, p0_write, p0_address, p0_writedata,
    output p1_read, p1_write, p1_address, p1_writedata,
    output mem_readdata, mem_ack,
    input  p0_readdata, p0_busywait,
    input  p1_readdata, p1_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one shared byte memory; IDLE/BUSY/DONE FSM with ack timeout.
// Ports: clk, rst_n (async low), bus (mem_arbiter_if.slave). MEM_ARBITER_RR_EN: round-robin, else P0 priority.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic       owner;
  logic [7:0] cnt;

  logic       req0;
  logic       req1;
  logic       win;
  logic       win_rd;
  logic [7:0] win_addr;
  logic [7:0] win_data;

  assign req0 = bus.p0_read | bus.p0_write;
  assign req1 = bus.p1_read | bus.p1_write;

  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    win = (req0 & req1) ? ~owner : ~req0;
`else
    win = ~req0;
`endif
    win_rd   = win ? bus.p1_read : bus.p0_read;
    win_addr = win ? bus.p1_address : bus.p0_address;
    win_data = win ? bus.p1_writedata : bus.p0_writedata;
  end

  assign bus.p0_busywait = req0 & ~((state == DONE) & ~owner);
  assign bus.p1_busywait = req1 & ~((state == DONE) & owner);

  // mem_read doubles as the latched access kind while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      owner             <= 1'b1;
      cnt               <= 8'h00;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= 8'h00;
      bus.mem_writedata <= 8'h00;
      bus.p0_readdata   <= 8'h00;
      bus.p1_readdata   <= 8'h00;
      bus.timeout_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner             <= win;
            bus.mem_read      <= win_rd;
            bus.mem_write     <= ~win_rd;
            bus.mem_address   <= win_addr;
            bus.mem_writedata <= win_data;
            cnt               <= 8'h00;
            state             <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            if (bus.mem_read) begin
              if (owner) bus.p1_readdata <= bus.mem_readdata;
              else       bus.p0_readdata <= bus.mem_readdata;
            end
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            state         <= DONE;
          end else if (cnt == TO) begin
            if (bus.mem_read) begin
              if (owner) bus.p1_readdata <= 8'hFF;
              else       bus.p0_readdata <= 8'hFF;
            end
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.timeout_err <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          bus.timeout_err <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4).
// Vector table of single accesses plus hand sequences for reset, stray ack and contention.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       p0_rd;
    logic       p0_wr;
    logic [7:0] p0_a;
    logic [7:0] p0_d;
    logic       p1_rd;
    logic       p1_wr;
    logic [7:0] p1_a;
    logic [7:0] p1_d;
    int         ack_wait;
    logic       no_ack;
    logic [7:0] mrd;
    logic       e_rd;
    logic       e_wr;
    logic [7:0] e_a;
    logic [7:0] e_d;
    logic [7:0] e_r0;
    logic [7:0] e_r1;
    logic       e_to;
    logic       e_bw0;
    logic       e_bw1;
  } vec_t;

  vec_t tv[7];

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.p0_read      = 1'b0;
    bus.p0_write     = 1'b0;
    bus.p0_address   = 8'h00;
    bus.p0_writedata = 8'h00;
    bus.p1_read      = 1'b0;
    bus.p1_write     = 1'b0;
    bus.p1_address   = 8'h00;
    bus.p1_writedata = 8'h00;
    bus.mem_ack      = 1'b0;
    bus.mem_readdata = 8'h00;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    bus.p0_read      = v.p0_rd;
    bus.p0_write     = v.p0_wr;
    bus.p0_address   = v.p0_a;
    bus.p0_writedata = v.p0_d;
    bus.p1_read      = v.p1_rd;
    bus.p1_write     = v.p1_wr;
    bus.p1_address   = v.p1_a;
    bus.p1_writedata = v.p1_d;
    @(negedge clk);
    chk1($sformatf("v%0d_mem_read", i), bus.mem_read, v.e_rd);
    chk1($sformatf("v%0d_mem_write", i), bus.mem_write, v.e_wr);
    chk8($sformatf("v%0d_mem_addr", i), bus.mem_address, v.e_a);
    chk8($sformatf("v%0d_mem_wdata", i), bus.mem_writedata, v.e_d);
    chk1($sformatf("v%0d_bw0_busy", i), bus.p0_busywait, v.p0_rd | v.p0_wr);
    chk1($sformatf("v%0d_bw1_busy", i), bus.p1_busywait, v.p1_rd | v.p1_wr);
    if (v.no_ack) begin
      repeat (4) @(negedge clk);
      chk1($sformatf("v%0d_still_busy", i), bus.mem_read, v.e_rd);
      @(negedge clk);
    end else begin
      repeat (v.ack_wait) @(negedge clk);
      chk8($sformatf("v%0d_addr_hold", i), bus.mem_address, v.e_a);
      bus.mem_ack      = 1'b1;
      bus.mem_readdata = v.mrd;
      @(negedge clk);
      bus.mem_ack      = 1'b0;
      bus.mem_readdata = 8'h00;
    end
    chk1($sformatf("v%0d_done_rd", i), bus.mem_read, 1'b0);
    chk1($sformatf("v%0d_done_wr", i), bus.mem_write, 1'b0);
    chk8($sformatf("v%0d_r0", i), bus.p0_readdata, v.e_r0);
    chk8($sformatf("v%0d_r1", i), bus.p1_readdata, v.e_r1);
    chk1($sformatf("v%0d_tmo", i), bus.timeout_err, v.e_to);
    chk1($sformatf("v%0d_bw0_done", i), bus.p0_busywait, v.e_bw0);
    chk1($sformatf("v%0d_bw1_done", i), bus.p1_busywait, v.e_bw1);
    idle_inputs();
    @(negedge clk);
    chk1($sformatf("v%0d_tmo_clear", i), bus.timeout_err, 1'b0);
    chk1($sformatf("v%0d_idle_rd", i), bus.mem_read, 1'b0);
  endtask

  logic       own_exp [3];
  logic [7:0] r1_final;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();

    tv[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0,
              8'h5A, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h30, 8'h77, 2, 1'b0,
              8'h00, 1'b0, 1'b1, 8'h30, 8'h77, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'h07, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0,
              8'hC3, 1'b1, 1'b0, 8'h07, 8'h99, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 0, 1'b0,
              8'h42, 1'b1, 1'b0, 8'h21, 8'h00, 8'hC3, 8'h42, 1'b0, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 0, 1'b1,
              8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 8'hC3, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b1, 8'h55, 8'hAB, 1'b0, 1'b0, 8'h00, 8'h00, 3, 1'b0,
              8'h00, 1'b0, 1'b1, 8'h55, 8'hAB, 8'hC3, 8'hFF, 1'b0, 1'b0, 1'b0};
`ifdef MEM_ARBITER_RR_EN
    tv[6] = '{1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 8'h61, 8'h00, 0, 1'b0,
              8'h11, 1'b1, 1'b0, 8'h61, 8'h00, 8'hC3, 8'h11, 1'b0, 1'b1, 1'b0};
    own_exp  = '{1'b0, 1'b1, 1'b0};
    r1_final = 8'hA1;
`else
    tv[6] = '{1'b1, 1'b0, 8'h60, 8'h00, 1'b1, 1'b0, 8'h61, 8'h00, 0, 1'b0,
              8'h11, 1'b1, 1'b0, 8'h60, 8'h00, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b1};
    own_exp  = '{1'b0, 1'b0, 1'b0};
    r1_final = 8'h00;
`endif

    repeat (2) @(negedge clk);
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk8("rst_mem_addr", bus.mem_address, 8'h00);
    chk8("rst_mem_wdata", bus.mem_writedata, 8'h00);
    chk8("rst_r0", bus.p0_readdata, 8'h00);
    chk8("rst_r1", bus.p1_readdata, 8'h00);
    chk1("rst_tmo", bus.timeout_err, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tv[i], i);

    // stray ack while idle
    @(negedge clk);
    bus.mem_ack      = 1'b1;
    bus.mem_readdata = 8'hEE;
    @(negedge clk);
    idle_inputs();
    chk1("stray_rd", bus.mem_read, 1'b0);
    chk1("stray_wr", bus.mem_write, 1'b0);
    chk8("stray_r0", bus.p0_readdata, tv[6].e_r0);
    chk8("stray_r1", bus.p1_readdata, tv[6].e_r1);
    chk1("stray_bw1", bus.p1_busywait, 1'b0);

    // async reset in the middle of an access
    @(negedge clk);
    bus.p0_read    = 1'b1;
    bus.p0_address = 8'h10;
    @(negedge clk);
    chk1("mid_busy_rd", bus.mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_rd", bus.mem_read, 1'b0);
    chk1("arst_wr", bus.mem_write, 1'b0);
    chk8("arst_addr", bus.mem_address, 8'h00);
    chk8("arst_r0", bus.p0_readdata, 8'h00);
    chk8("arst_r1", bus.p1_readdata, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_idle", bus.mem_read, 1'b0);

    // both ports held for three accesses
    bus.p0_write     = 1'b1;
    bus.p0_address   = 8'h20;
    bus.p0_writedata = 8'h33;
    bus.p1_read      = 1'b1;
    bus.p1_address   = 8'h21;
    bus.mem_readdata = 8'hA1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk8($sformatf("arb%0d_addr", k), bus.mem_address,
           own_exp[k] ? 8'h21 : 8'h20);
      chk1($sformatf("arb%0d_wr", k), bus.mem_write, ~own_exp[k]);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk1($sformatf("arb%0d_bw0", k), bus.p0_busywait, own_exp[k]);
      chk1($sformatf("arb%0d_bw1", k), bus.p1_busywait, ~own_exp[k]);
      @(negedge clk);
      chk1($sformatf("arb%0d_idle_bw0", k), bus.p0_busywait, 1'b1);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    chk8("arb_r1_final", bus.p1_readdata, r1_final);
    chk8("arb_r0_final", bus.p0_readdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
